// File: rtl/comm_rsp_encoder.sv
// comm_rsp_encoder: turns one backend response (read data, write ack or
// error code) into an ASCII line. The line goes out one byte per
// valid/ready handshake to the UART transmitter.
// Lines are "0x" + 8 hex digits for a read, "OK" for a write ack, and
// "E" + 2 code chars for an error.
// Build option COMM_RSP_CRLF_EN: when defined, lines end in CR LF.
// When it is not defined, lines end in LF only.

module comm_rsp_encoder #(
    parameter bit HEX_UPPER = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic        rsp_is_read,
    input  logic        rsp_err,
    input  logic [31:0] rsp_rddata,
    input  logic [15:0] rsp_err_code,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rsp_done,
    output logic        busy
);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    typedef enum logic [1:0] {
        LT_WRITE,
        LT_READ,
        LT_ERR
    } line_t;

    // The line terminator is either CR LF or a bare LF. Only the count and
    // the CR slot change; everything else is shared.
`ifdef COMM_RSP_CRLF_EN
    localparam logic [3:0] TERM_LEN = 4'd2;
    localparam bit         TERM_CR  = 1'b1;
`else
    localparam logic [3:0] TERM_LEN = 4'd1;
    localparam bit         TERM_CR  = 1'b0;
`endif

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Number of payload bytes before the terminator, for each line type.
    function automatic logic [3:0] body_len(input line_t t);
        logic [3:0] len;
        case (t)
            LT_ERR:  len = 4'd3;
            LT_READ: len = 4'd10;
            default: len = 4'd2;
        endcase
        return len;
    endfunction

    // Converts one nibble to an ASCII hex digit in the configured case.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else if (HEX_UPPER) begin
            c = 8'h41 + {4'h0, nib - 4'd10};
        end else begin
            c = 8'h61 + {4'h0, nib - 4'd10};
        end
        return c;
    endfunction

    // Byte at position idx of a line of type t, built from the captured
    // payload. Read digits run from nibble [31:28] at idx 2 down to
    // nibble [3:0] at idx 9.
    function automatic logic [7:0] line_byte(
        input line_t       t,
        input logic [3:0]  idx,
        input logic [31:0] data,
        input logic [15:0] code
    );
        logic [7:0] b;
        logic [3:0] blen;
        logic [2:0] sel;
        logic [4:0] lsb;
        b    = CH_LF;
        blen = body_len(t);
        sel  = 3'(4'd9 - idx);
        lsb  = {sel, 2'b00};
        if (idx >= blen) begin
            b = (TERM_CR && (idx == blen)) ? CH_CR : CH_LF;
        end else begin
            case (t)
                LT_ERR: begin
                    case (idx)
                        4'd0:    b = "E";
                        4'd1:    b = code[7:0];
                        default: b = code[15:8];
                    endcase
                end
                LT_READ: begin
                    if (idx == 4'd0) begin
                        b = "0";
                    end else if (idx == 4'd1) begin
                        b = "x";
                    end else begin
                        b = hex_char(data[lsb +: 4]);
                    end
                end
                default: begin
                    b = (idx == 4'd0) ? "O" : "K";
                end
            endcase
        end
        return b;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    line_t       r_type;
    logic [3:0]  r_idx;
    logic [31:0] r_rddata;
    logic [15:0] r_err_code;
    logic [7:0]  r_tx_data;
    logic        r_rsp_done;

    line_t       w_in_type;
    logic        w_capture;
    logic        w_accept;
    logic        w_at_last;
    logic [3:0]  w_last_idx;
    logic [7:0]  w_first_byte;
    logic [7:0]  w_next_byte;

    // Classify the incoming response. An error outranks the read/write flag.
    always_comb begin
        w_in_type = LT_WRITE;
        if (rsp_err) begin
            w_in_type = LT_ERR;
        end else if (rsp_is_read) begin
            w_in_type = LT_READ;
        end
    end

    // Handshake qualifiers and the bytes that are staged into the output register.
    always_comb begin
        w_capture    = (r_state == ST_IDLE) && rsp_valid;
        w_accept     = (r_state == ST_SEND) && tx_ready;
        w_last_idx   = body_len(r_type) + TERM_LEN - 4'd1;
        w_at_last    = (r_idx == w_last_idx);
        w_first_byte = line_byte(w_in_type, 4'd0, rsp_rddata, rsp_err_code);
        w_next_byte  = line_byte(r_type, r_idx + 4'd1, r_rddata, r_err_code);
    end

    // State register: a reset aborts any line in progress at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave IDLE on capture and return after the last byte is taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rsp_valid) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready && w_at_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs: ready and busy come from the state, and the byte and pulse are registered.
    always_comb begin
        rsp_ready = (r_state == ST_IDLE);
        tx_valid  = (r_state == ST_SEND);
        busy      = (r_state == ST_SEND);
        tx_data   = r_tx_data;
        rsp_done  = r_rsp_done;
    end

    // Datapath: capture the payload once, then step through the line one byte per accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_type     <= LT_WRITE;
            r_idx      <= 4'd0;
            r_rddata   <= 32'h0;
            r_err_code <= 16'h0;
            r_tx_data  <= 8'h00;
            r_rsp_done <= 1'b0;
        end else begin
            r_rsp_done <= 1'b0;
            if (w_capture) begin
                r_type     <= w_in_type;
                r_idx      <= 4'd0;
                r_rddata   <= rsp_rddata;
                r_err_code <= rsp_err_code;
                r_tx_data  <= w_first_byte;
            end else if (w_accept) begin
                if (w_at_last) begin
                    r_rsp_done <= 1'b1;
                end else begin
                    r_idx     <= r_idx + 4'd1;
                    r_tx_data <= w_next_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_comm_rsp_encoder.sv
// tb_comm_rsp_encoder: directed vector table, hand sequences and random responses.
// Two encoders (upper-case and lower-case hex) share all inputs and are checked side by side.

module tb_comm_rsp_encoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rspValid;
    logic        rspIsRead;
    logic        rspErr;
    logic [31:0] rspRddata;
    logic [15:0] rspErrCode;
    logic        txReady;

    logic        rspReadyU, txValidU, rspDoneU, busyU;
    logic [7:0]  txDataU;
    logic        rspReadyL, txValidL, rspDoneL, busyL;
    logic [7:0]  txDataL;

    int checks = 0;
    int errors = 0;

    typedef logic [7:0] byte_q[$];

    typedef struct {
        bit          isRead;
        bit          err;
        logic [31:0] data;
        logic [15:0] code;
        int          bodyLen;
        logic [79:0] bodyUp;
        logic [79:0] bodyLo;
        int          stallIdx;
        int          stallLen;
    } vec_t;

    vec_t vecs[8];

    comm_rsp_encoder #(.HEX_UPPER(1'b1)) dutUp (
        .clk(clk), .rstn(rstn),
        .rsp_valid(rspValid), .rsp_ready(rspReadyU),
        .rsp_is_read(rspIsRead), .rsp_err(rspErr),
        .rsp_rddata(rspRddata), .rsp_err_code(rspErrCode),
        .tx_data(txDataU), .tx_valid(txValidU), .tx_ready(txReady),
        .rsp_done(rspDoneU), .busy(busyU)
    );

    comm_rsp_encoder #(.HEX_UPPER(1'b0)) dutLo (
        .clk(clk), .rstn(rstn),
        .rsp_valid(rspValid), .rsp_ready(rspReadyL),
        .rsp_is_read(rspIsRead), .rsp_err(rspErr),
        .rsp_rddata(rspRddata), .rsp_err_code(rspErrCode),
        .tx_data(txDataL), .tx_valid(txValidL), .tx_ready(txReady),
        .rsp_done(rspDoneL), .busy(busyL)
    );

    always #5 clk = ~clk;

    // Append the line terminator for the current build.
    function automatic byte_q addTerm(input byte_q q);
        byte_q r;
        r = q;
`ifdef COMM_RSP_CRLF_EN
        r.push_back(8'h0D);
`endif
        r.push_back(8'h0A);
        return r;
    endfunction

    // Expected line from a literal body; the first character is the most significant byte in use.
    function automatic byte_q fromBody(input logic [79:0] body, input int len);
        byte_q q;
        for (int i = 0; i < len; i++) begin
            q.push_back(body[8*(len-1-i) +: 8]);
        end
        return addTerm(q);
    endfunction

    // Reference model: build the whole line from the response fields.
    function automatic byte_q modelLine(input bit isRead, input bit err, input logic [31:0] d,
                                        input logic [15:0] code, input bit upper);
        byte_q q;
        int nib;
        if (err) begin
            q.push_back("E");
            q.push_back(code[7:0]);
            q.push_back(code[15:8]);
        end else if (isRead) begin
            q.push_back("0");
            q.push_back("x");
            for (int k = 7; k >= 0; k--) begin
                nib = int'((d >> (4 * k)) & 32'hF);
                if (nib < 10) q.push_back(8'(48 + nib));
                else          q.push_back(8'((upper ? 65 : 97) + nib - 10));
            end
        end else begin
            q.push_back("O");
            q.push_back("K");
        end
        return addTerm(q);
    endfunction

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one response at a falling edge and hold it through the capturing rising edge.
    task automatic applyStimulus(input bit isRead, input bit err, input logic [31:0] data,
                                 input logic [15:0] code, input bit keepValid);
        @(negedge clk);
        rspIsRead  = isRead;
        rspErr     = err;
        rspRddata  = data;
        rspErrCode = code;
        rspValid   = 1'b1;
        checkOutput("rsp_ready up before capture", 32'(rspReadyU), 32'd1);
        checkOutput("rsp_ready lo before capture", 32'(rspReadyL), 32'd1);
        @(posedge clk);
        #1;
        if (!keepValid) rspValid = 1'b0;
        rspIsRead  = 1'($urandom);
        rspErr     = 1'($urandom);
        rspRddata  = $urandom;
        rspErrCode = 16'($urandom);
    endtask

    // Collect one line after capture, with optional stalls, and check the rsp_done cycle.
    task automatic collectLine(input byte_q expUp, input byte_q expLo, input int stallIdx,
                               input int stallLen, input bit randReady, input string tag);
        int got;
        int cyc;
        int stallLeft;
        bit prevHeld;
        logic [7:0] prevUp;
        logic [7:0] prevLo;
        got = 0;
        cyc = 0;
        stallLeft = stallLen;
        prevHeld = 1'b0;
        prevUp = 8'h00;
        prevLo = 8'h00;
        while (got < expUp.size() && cyc < 200) begin
            @(negedge clk);
            cyc++;
            checkOutput({tag, " tx_valid up"}, 32'(txValidU), 32'd1);
            checkOutput({tag, " tx_valid lo"}, 32'(txValidL), 32'd1);
            checkOutput({tag, " busy"}, 32'(busyU), 32'd1);
            checkOutput({tag, " rsp_ready low"}, 32'(rspReadyU), 32'd0);
            checkOutput({tag, " rsp_done mid-line"}, 32'(rspDoneU | rspDoneL), 32'd0);
            if (prevHeld) begin
                checkOutput({tag, " hold tx_data up"}, 32'(txDataU), 32'(prevUp));
                checkOutput({tag, " hold tx_data lo"}, 32'(txDataL), 32'(prevLo));
            end
            if (stallIdx == got && stallLeft > 0) begin
                txReady = 1'b0;
                stallLeft--;
            end else if (randReady) begin
                txReady = ($urandom_range(0, 2) != 0);
            end else begin
                txReady = 1'b1;
            end
            if (txReady) begin
                checkOutput($sformatf("%s byte %0d up", tag, got), 32'(txDataU), 32'(expUp[got]));
                checkOutput($sformatf("%s byte %0d lo", tag, got), 32'(txDataL), 32'(expLo[got]));
                got++;
            end
            prevHeld = !txReady;
            prevUp = txDataU;
            prevLo = txDataL;
        end
        if (got < expUp.size()) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got %0d bytes, expected %0d", tag, got, expUp.size());
        end
        if (!randReady) begin
            checkOutput({tag, " line cycles"}, 32'(cyc), 32'(expUp.size() + stallLen));
        end
        @(negedge clk);
        txReady = 1'b1;
        checkOutput({tag, " end tx_valid"}, 32'(txValidU | txValidL), 32'd0);
        checkOutput({tag, " rsp_done up"}, 32'(rspDoneU), 32'd1);
        checkOutput({tag, " rsp_done lo"}, 32'(rspDoneL), 32'd1);
        checkOutput({tag, " end rsp_ready"}, 32'(rspReadyU & rspReadyL), 32'd1);
        checkOutput({tag, " end busy"}, 32'(busyU | busyL), 32'd0);
    endtask

    // Run one complete transaction and check that the done pulse lasts a single cycle.
    task automatic sendAndCheck(input bit isRead, input bit err, input logic [31:0] data,
                                input logic [15:0] code, input byte_q expUp, input byte_q expLo,
                                input int stallIdx, input int stallLen, input bit randReady,
                                input string tag);
        applyStimulus(isRead, err, data, code, 1'b0);
        collectLine(expUp, expLo, stallIdx, stallLen, randReady, tag);
        @(negedge clk);
        checkOutput({tag, " rsp_done one cycle"}, 32'(rspDoneU | rspDoneL), 32'd0);
    endtask

    initial begin
        bit          rIsRead;
        bit          rErr;
        logic [31:0] rData;
        logic [15:0] rCode;

        vecs[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 16'h0000, 10, "0xDEADBEEF", "0xdeadbeef", -1, 0};
        vecs[1] = '{1'b0, 1'b0, 32'h12345678, 16'h5A5A, 2, "OK", "OK", -1, 0};
        vecs[2] = '{1'b1, 1'b1, 32'hFFFFFFFF, 16'h3130, 3, "E01", "E01", -1, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000000A, 16'h0000, 10, "0x0000000A", "0x0000000a", 2, 3};
        vecs[4] = '{1'b1, 1'b0, 32'h12345678, 16'h0000, 10, "0x12345678", "0x12345678", -1, 0};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFFFFFF, 16'h0000, 10, "0xFFFFFFFF", "0xffffffff", 0, 2};
        vecs[6] = '{1'b0, 1'b1, 32'h00000000, 16'hFF00, 3, 80'h4500FF, 80'h4500FF, 3, 1};
        vecs[7] = '{1'b1, 1'b0, 32'h9ABCDEF0, 16'h0000, 10, "0x9ABCDEF0", "0x9abcdef0", 9, 2};

        rstn       = 1'b1;
        rspValid   = 1'b0;
        rspIsRead  = 1'b0;
        rspErr     = 1'b0;
        rspRddata  = 32'h0;
        rspErrCode = 16'h0;
        txReady    = 1'b1;
        #1 rstn = 1'b0;
        #11;
        checkOutput("reset rsp_ready", 32'(rspReadyU & rspReadyL), 32'd1);
        checkOutput("reset tx_valid", 32'(txValidU | txValidL), 32'd0);
        checkOutput("reset tx_data up", 32'(txDataU), 32'd0);
        checkOutput("reset tx_data lo", 32'(txDataL), 32'd0);
        checkOutput("reset rsp_done", 32'(rspDoneU | rspDoneL), 32'd0);
        checkOutput("reset busy", 32'(busyU | busyL), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            sendAndCheck(vecs[i].isRead, vecs[i].err, vecs[i].data, vecs[i].code,
                         fromBody(vecs[i].bodyUp, vecs[i].bodyLen),
                         fromBody(vecs[i].bodyLo, vecs[i].bodyLen),
                         vecs[i].stallIdx, vecs[i].stallLen, 1'b0, $sformatf("vec%0d", i));
        end

        // Back-to-back: rsp_valid stays high and the inputs switch to the second response after the first capture.
        applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
        rspIsRead  = 1'b1;
        rspErr     = 1'b0;
        rspRddata  = 32'hCAFE0123;
        rspErrCode = 16'h4142;
        collectLine(fromBody("OK", 2), fromBody("OK", 2), -1, 0, 1'b0, "b2b first");
        @(posedge clk);
        #1;
        rspValid  = 1'b0;
        rspRddata = 32'h0;
        collectLine(fromBody("0xCAFE0123", 10), fromBody("0xcafe0123", 10), -1, 0, 1'b0, "b2b second");
        @(negedge clk);
        checkOutput("b2b rsp_done one cycle", 32'(rspDoneU), 32'd0);

        // Reset in the middle of a line: the line is dropped at once and no rsp_done follows.
        applyStimulus(1'b1, 1'b0, 32'h87654321, 16'h0, 1'b0);
        txReady = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checkOutput("midreset tx_valid", 32'(txValidU | txValidL), 32'd0);
        checkOutput("midreset rsp_ready", 32'(rspReadyU & rspReadyL), 32'd1);
        checkOutput("midreset busy", 32'(busyU | busyL), 32'd0);
        checkOutput("midreset tx_data", 32'(txDataU), 32'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("midreset no rsp_done", 32'(rspDoneU | rspDoneL), 32'd0);
            checkOutput("midreset idle tx_valid", 32'(txValidU | txValidL), 32'd0);
        end
        rstn = 1'b1;
        sendAndCheck(1'b0, 1'b0, 32'h0, 16'h0, fromBody("OK", 2), fromBody("OK", 2),
                     -1, 0, 1'b0, "after reset");

        // Random responses checked against the reference model, with random backpressure.
        for (int n = 0; n < 40; n++) begin
            rIsRead = 1'($urandom);
            rErr    = ($urandom_range(0, 3) == 0);
            rData   = (n % 5 == 0) ? {8{4'($urandom_range(9, 10))}} : $urandom;
            rCode   = 16'($urandom);
            sendAndCheck(rIsRead, rErr, rData, rCode,
                         modelLine(rIsRead, rErr, rData, rCode, 1'b1),
                         modelLine(rIsRead, rErr, rData, rCode, 1'b0),
                         -1, 0, 1'b1, $sformatf("rand%0d", n));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
